// File: rtl/ch_sched.sv
`default_nettype none
// ============================================================================
// Module      : ch_sched
// Description : Per-channel DMA transfer sequencer. It shares one wishbone
//               master between source-FIFO read bursts and destination-FIFO
//               write bursts using round-robin arbitration.
//               The optional stall watchdog is enabled by CH_SCHED_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ch_sched #(
    parameter int MAX_BURST = 16,
    parameter int BW        = 8,
    parameter int WD_CYCLES = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        go_i,
    input  logic        abort_i,
    input  logic [23:0] dc0,
    input  logic        ss_start0,
    input  logic        ss_stop0,
    input  logic        ss_start1,
    input  logic        ss_stop1,
    input  logic        ss_end1,
    input  logic        ack_i,
    output logic        req_o,
    output logic        we_o,
    output logic        ss_xfer0,
    output logic        ss_last0,
    output logic        ss_xfer1,
    output logic        m_reset0,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLR  = 3'd1;
    localparam logic [2:0] S_ARB  = 3'd2;
    localparam logic [2:0] S_RD   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [23:0]   rem;
    logic [BW-1:0] beat;
    logic          wr_done;
    logic          last_wr;
    logic          abort_pend;
    logic          rd_ok;
    logic          wr_ok;
    logic          grant_rd;
    logic          grant_wr;
    logic          all_done;
    logic          rd_end;
    logic          wr_end;
    logic          kill;
    logic          wd_fire;

    assign rd_ok    = (rem != 24'd0) & ss_start0 & ~ss_stop0;
    assign wr_ok    = ~wr_done & ss_start1;
    assign grant_rd = rd_ok & (~wr_ok | last_wr);
    assign grant_wr = wr_ok & (~rd_ok | ~last_wr);
    assign all_done = (rem == 24'd0) & wr_done;
    // A stop on the source side ends the burst even when it coincides with an ack.
    assign rd_end   = (ack_i & ((beat == BEAT_LAST) | (rem == 24'd1))) | ss_stop0;
    assign wr_end   = (ack_i & ((beat == BEAT_LAST) | ss_end1)) | (ss_stop1 & ~ack_i);
    assign kill     = (state != S_IDLE) & (abort_i | wd_fire);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            rem        <= 24'd0;
            beat       <= '0;
            wr_done    <= 1'b0;
            last_wr    <= 1'b0;
            abort_pend <= 1'b0;
            req_o      <= 1'b0;
            we_o       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (go_i) begin
                        rem        <= dc0;
                        wr_done    <= 1'b0;
                        abort_pend <= 1'b0;
                    end
                end
                S_CLR: begin
                    abort_pend <= 1'b0;
                end
                S_ARB: begin
                    if (!all_done && grant_rd) begin
                        req_o   <= 1'b1;
                        we_o    <= 1'b0;
                        beat    <= '0;
                        last_wr <= 1'b0;
                    end else if (!all_done && grant_wr) begin
                        req_o   <= 1'b1;
                        we_o    <= 1'b1;
                        beat    <= '0;
                        last_wr <= 1'b1;
                    end
                end
                S_RD: begin
                    if (ack_i) begin
                        if (rem != 24'd0) begin
                            rem <= rem - 24'd1;
                        end
                        beat <= beat + BW'(1);
                    end
                    if (rd_end) begin
                        req_o <= 1'b0;
                    end
                end
                S_WR: begin
                    if (ack_i) begin
                        beat <= beat + BW'(1);
                        if (ss_end1) begin
                            wr_done <= 1'b1;
                        end
                    end
                    if (wr_end) begin
                        req_o <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
            // Abort/timeout takes precedence over any grant or burst bookkeeping above.
            if (kill) begin
                req_o      <= 1'b0;
                abort_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = S_CLR;
        end else begin
            case (state)
                S_IDLE:  if (go_i) state_nxt = S_CLR;
                S_CLR:   state_nxt = abort_pend ? S_IDLE : S_ARB;
                S_ARB: begin
                    if (all_done)      state_nxt = S_FIN;
                    else if (grant_rd) state_nxt = S_RD;
                    else if (grant_wr) state_nxt = S_WR;
                end
                S_RD:    if (rd_end) state_nxt = S_ARB;
                S_WR:    if (wr_end) state_nxt = S_ARB;
                S_FIN:   state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        m_reset0 = (state == S_CLR);
        busy_o   = (state != S_IDLE);
        done_o   = (state == S_FIN);
        ss_xfer0 = ack_i & (state == S_RD);
        ss_last0 = ack_i & (state == S_RD) & (rem == 24'd1);
        ss_xfer1 = ack_i & (state == S_WR);
    end

`ifdef CH_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);

    logic [WDW-1:0] wd_cnt;

    assign wd_fire = req_o & ~ack_i & (wd_cnt == WDW'(WD_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wd_cnt <= '0;
            err_o  <= 1'b0;
        end else begin
            if (req_o & ~ack_i & ~wd_fire) begin
                wd_cnt <= wd_cnt + WDW'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (wd_fire) begin
                err_o <= 1'b1;
            end else if (go_i && (state == S_IDLE)) begin
                err_o <= 1'b0;
            end
        end
    end
`else
    // No stall timeout: a hung slave is released only by abort_i or reset.
    assign wd_fire = 1'b0;
    if (WD_CYCLES > 0) begin : g_wd_off
        assign err_o = 1'b0;
    end else begin : g_wd_off_degenerate
        assign err_o = 1'b0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ch_sched.sv
`default_nettype none
// Testbench for ch_sched: a FIFO/bus environment model drives the DUT, and
// transfer totals, burst shapes and pulses are compared with values derived from the descriptor.
module tb_ch_sched;

    logic        clk = 1'b0;
    logic        wb_rst_i, go_i, abort_i, ss_start0, ss_stop0, ss_start1, ss_stop1, ss_end1, ack_i;
    logic [23:0] dc0;
    logic        req_o, we_o, ss_xfer0, ss_last0, ss_xfer1, m_reset0, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    ch_sched #(.MAX_BURST(16), .BW(8), .WD_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .go_i(go_i), .abort_i(abort_i), .dc0(dc0),
        .ss_start0(ss_start0), .ss_stop0(ss_stop0), .ss_start1(ss_start1), .ss_stop1(ss_stop1),
        .ss_end1(ss_end1), .ack_i(ack_i), .req_o(req_o), .we_o(we_o), .ss_xfer0(ss_xfer0),
        .ss_last0(ss_last0), .ss_xfer1(ss_xfer1), .m_reset0(m_reset0), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // environment knobs
    bit rst_k, go_req, abort_req, ack_force, ack_en, start0_k, stop0_k, rand_stop, force_start1, hold;
    int ack_pct;
    int cur_dc;
    // destination FIFO model: words available, and whether the marked last word is inside
    int dst_avail;
    bit end_flag;
    // monitor
    int rd_total, wr_total, last0_cnt, last0_at, done_cnt, mrst_cnt;
    bit in_burst;
    int cur_beats, cur_we, gap_len;
    int b_we[$];
    int b_len[$];
    int gaps[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_total = 0; wr_total = 0; last0_cnt = 0; last0_at = 0; done_cnt = 0; mrst_cnt = 0;
        in_burst = 0; cur_beats = 0; cur_we = 0; gap_len = 0;
        b_we.delete(); b_len.delete(); gaps.delete();
        dst_avail = 0; end_flag = 0;
    endtask

    // One clock: drive inputs after the falling edge, sample 1ns later.
    task automatic tick();
        @(negedge clk);
        wb_rst_i  = rst_k;
        go_i      = go_req;
        abort_i   = abort_req;
        go_req    = 0;
        abort_req = 0;
        ss_start0 = start0_k;
        ss_stop0  = stop0_k || (rand_stop && ($urandom_range(99) < 8));
        ss_start1 = force_start1 || ((dst_avail > 0) && !(hold && rd_total < cur_dc));
        ss_stop1  = (dst_avail == 0);
        ss_end1   = end_flag && (dst_avail == 1);
        ack_i     = ack_force || (req_o && ack_en && ($urandom_range(99) < ack_pct)
                                  && (!we_o || dst_avail > 0));
        #1;
        if (ss_xfer0) begin
            rd_total++;
            dst_avail++;
            if (ss_last0) begin
                last0_cnt++;
                last0_at = rd_total;
                end_flag = 1;
            end
        end
        if (ss_xfer1) begin
            wr_total++;
            if (dst_avail > 0) dst_avail--;
            if (ss_end1) end_flag = 0;
        end
        if (m_reset0) mrst_cnt++;
        if (done_o) done_cnt++;
        if (req_o) begin
            if (!in_burst) begin
                in_burst  = 1;
                cur_beats = 0;
                cur_we    = int'(we_o);
                if (b_len.size() > 0) gaps.push_back(gap_len);
            end
            if (ss_xfer0 || ss_xfer1) cur_beats++;
        end else begin
            if (in_burst) begin
                in_burst = 0;
                b_we.push_back(cur_we);
                b_len.push_back(cur_beats);
                gap_len = 0;
            end
            gap_len++;
        end
    endtask

    task automatic start_desc(input int dc, input bit preload);
        clear_mon();
        if (preload) begin
            dst_avail = 1;
            end_flag  = 1;
        end
        cur_dc = dc;
        dc0    = 24'(dc);
        go_req = 1;
        tick();
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, int'(n < budget), 1);
        if (n >= budget) begin
            rst_k = 1; tick(); rst_k = 0;
        end
        tick();
        chk({tag, "_busy_after"}, int'(busy_o), 0);
    endtask

    task automatic chk_bursts(input string tag, input int we_exp[$], input int len_exp[$]);
        chk({tag, "_nbursts"}, b_len.size(), len_exp.size());
        for (int i = 0; i < len_exp.size(); i++) begin
            chk($sformatf("%s_we%0d", tag, i), b_we[i], we_exp[i]);
            chk($sformatf("%s_len%0d", tag, i), b_len[i], len_exp[i]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed still running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int maxb;
        wb_rst_i = 1; go_i = 0; abort_i = 0; dc0 = 0; ss_start0 = 0; ss_stop0 = 0;
        ss_start1 = 0; ss_stop1 = 0; ss_end1 = 0; ack_i = 0;
        rst_k = 1; ack_force = 1; ack_en = 1; ack_pct = 100; start0_k = 1; stop0_k = 0;
        rand_stop = 0; force_start1 = 0; hold = 0; cur_dc = 0;
        clear_mon();

        // reset values, with ack forced high to show it is ignored
        repeat (3) tick();
        chk("rst_req", int'(req_o), 0);
        chk("rst_we", int'(we_o), 0);
        chk("rst_xfer0", int'(ss_xfer0), 0);
        chk("rst_xfer1", int'(ss_xfer1), 0);
        chk("rst_last0", int'(ss_last0), 0);
        chk("rst_mreset", int'(m_reset0), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        rst_k = 0;

        // ack outside RD/WR is ignored
        clear_mon();
        repeat (3) tick();
        chk("idle_ack_strobes", rd_total + wr_total, 0);

        // dc0=4, ack every cycle
        start_desc(4, 0);
        wait_done(200, "t1");
        chk("t1_rd", rd_total, 4);
        chk("t1_last_cnt", last0_cnt, 1);
        chk("t1_last_at", last0_at, 4);
        chk("t1_wr", wr_total, 4);
        chk("t1_mreset_cycles", mrst_cnt, 1);
        chk("t1_done_cycles", done_cnt, 1);
        chk_bursts("t1", '{0, 1}, '{4, 4});
        ack_force = 0;

        // dc0=40, writes held back until all reads are in: 16/16/8 then 16/16/8
        hold = 1;
        start_desc(40, 0);
        wait_done(500, "t2");
        chk_bursts("t2", '{0, 0, 0, 1, 1, 1}, '{16, 16, 8, 16, 16, 8});
        chk("t2_ngaps", gaps.size(), 5);
        for (int i = 0; i < gaps.size(); i++) chk($sformatf("t2_gap%0d", i), gaps[i], 1);
        chk("t2_last_at", last0_at, 40);
        chk("t2_last_cnt", last0_cnt, 1);

        // both sides requesting: grants alternate
        hold = 0; force_start1 = 1;
        start_desc(64, 0);
        wait_done(1000, "t3");
        chk("t3_nbursts_ge5", int'(b_we.size() >= 5), 1);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_alt%0d", i), int'(b_we[i] != b_we[i+1]), 1);
        chk("t3_rd", rd_total, 64);
        chk("t3_wr", wr_total, 64);
        force_start1 = 0;

        // source stop coinciding with the 5th ack
        hold = 1;
        start_desc(20, 0);
        n = 0;
        while (rd_total < 4 && n < 100) begin tick(); n++; end
        stop0_k = 1;
        tick();
        chk("t4_rd_at_stop", rd_total, 5);
        repeat (4) tick();
        chk("t4_rd_while_stopped", rd_total, 5);
        stop0_k = 0;
        wait_done(500, "t4");
        chk_bursts("t4", '{0, 0, 1, 1}, '{5, 15, 16, 4});

        // abort in the middle of a write burst
        start_desc(8, 0);
        n = 0;
        while (wr_total < 3 && n < 200) begin tick(); n++; end
        abort_req = 1;
        tick();
        chk("t5_abort_beat_strobed", wr_total, 4);
        tick();
        chk("t5_req_dropped", int'(req_o), 0);
        chk("t5_mreset", int'(m_reset0), 1);
        tick();
        chk("t5_idle", int'(busy_o), 0);
        chk("t5_mreset_single", int'(m_reset0), 0);
        repeat (5) tick();
        chk("t5_no_done", done_cnt, 0);
        chk("t5_mreset_total", mrst_cnt, 2);

        // reset in the middle of a read burst
        start_desc(40, 0);
        n = 0;
        while (rd_total < 6 && n < 100) begin tick(); n++; end
        rst_k = 1;
        tick();
        rst_k = 0;
        tick();
        chk("t6_req", int'(req_o), 0);
        chk("t6_busy", int'(busy_o), 0);
        chk("t6_mreset", int'(m_reset0), 0);
        repeat (5) tick();
        chk("t6_no_done", done_cnt, 0);
        chk("t6_mreset_total", mrst_cnt, 1);
        hold = 0;

        // dc0=0: no reads, a single end-marked word drains
        start_desc(0, 1);
        wait_done(100, "t7");
        chk("t7_rd", rd_total, 0);
        chk("t7_wr", wr_total, 1);
        chk("t7_last_cnt", last0_cnt, 0);

        // randomized descriptors with random acks and source stops
        ack_pct = 70; rand_stop = 1;
        for (int k = 0; k < 6; k++) begin
            int dc;
            dc = (k == 0) ? 1 : (k == 1) ? 17 : int'($urandom_range(70, 2));
            start_desc(dc, 0);
            wait_done(4000, $sformatf("r%0d", k));
            chk($sformatf("r%0d_rd", k), rd_total, dc);
            chk($sformatf("r%0d_wr", k), wr_total, dc);
            chk($sformatf("r%0d_last_cnt", k), last0_cnt, 1);
            chk($sformatf("r%0d_last_at", k), last0_at, dc);
            chk($sformatf("r%0d_done", k), done_cnt, 1);
            chk($sformatf("r%0d_mreset", k), mrst_cnt, 1);
            maxb = 0;
            foreach (b_len[i]) if (b_len[i] > maxb) maxb = b_len[i];
            chk($sformatf("r%0d_burst_le16", k), int'(maxb <= 16), 1);
        end
        ack_pct = 100; rand_stop = 0;

`ifdef CH_SCHED_WATCHDOG_EN
        // stalled read burst trips the watchdog after 8 cycles
        ack_en = 0; hold = 1;
        start_desc(4, 0);
        n = 0;
        while (!req_o && n < 20) begin tick(); n++; end
        chk("wd_req_seen", int'(req_o), 1);
        repeat (7) tick();
        chk("wd_err_not_yet", int'(err_o), 0);
        tick();
        chk("wd_err_set", int'(err_o), 1);
        chk("wd_req_dropped", int'(req_o), 0);
        chk("wd_mreset", int'(m_reset0), 1);
        tick();
        chk("wd_idle", int'(busy_o), 0);
        chk("wd_no_done", done_cnt, 0);
        ack_en = 1; hold = 0;
        start_desc(4, 0);
        chk("wd_err_cleared", int'(err_o), 0);
        wait_done(200, "wd_rerun");
`else
        chk("err_tied_low", int'(err_o), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ch_sched.md
Name: ch_sched

Overview:
- Per-channel transfer sequencer for the SS DMA channel FIFO pair.
- Owns one wishbone master port and time-shares it between two burst types:
  - read bursts, which fill the source FIFO;
  - write bursts, which drain the destination FIFO.
- Drives the FIFO-side strobes ss_xfer0/ss_xfer1 and ss_last0, and clears the channel (m_reset0) at descriptor start.
- Reports completion when all source words are fetched and the destination end-marked word has been written out.

Parameters:
- MAX_BURST, 16, maximum beats per bus burst (power of two, 2..256).
- BW, 8, burst beat counter width (must satisfy 2^BW >= MAX_BURST).
- WD_CYCLES, 1024, cycles without an acknowledge before the watchdog fires (only used with CH_SCHED_WATCHDOG_EN).

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- go_i  in  1  one-cycle pulse: start descriptor; ignored unless in IDLE
- abort_i  in  1  level: abandon current descriptor
- dc0  in  24  source word count (64-bit words) for the descriptor; sampled on go_i
- ss_start0  in  1  source FIFO has room for a burst
- ss_stop0  in  1  source FIFO almost full
- ss_start1  in  1  destination FIFO has a burst available or end pending
- ss_stop1  in  1  destination FIFO almost empty
- ss_end1  in  1  destination FIFO head word carries the last marker
- ack_i  in  1  bus beat acknowledge
- req_o  out  1  bus cycle request (registered)
- we_o  out  1  1 = write burst, 0 = read burst (registered)
- ss_xfer0  out  1  source FIFO write strobe
- ss_last0  out  1  last-word marker into the source FIFO
- ss_xfer1  out  1  destination FIFO read strobe
- m_reset0  out  1  channel FIFO clear
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky watchdog error; cleared on go_i

Behaviour:
- Reset values: all outputs 0, state IDLE, remaining count 0, round-robin pointer = read.
- States: IDLE, CLR, ARB, RD, WR, FIN.
- IDLE:
  - On go_i, latch dc0 into rem, clear wr_done, go to CLR.
  - If dc0 == 0, rem is 0 and no reads are ever issued.
- CLR:
  - m_reset0 = 1 for exactly one cycle, then ARB.
- ARB:
  - rd_ok = (rem != 0) & ss_start0 & ~ss_stop0.
  - wr_ok = ~wr_done & ss_start1.
  - If both are ok, grant the side opposite the last grant (round robin); otherwise grant whichever is ok.
  - Granting clears the beat counter, sets req_o, sets we_o (0 for RD, 1 for WR), and enters RD/WR the next cycle.
  - If rem == 0 and wr_done, go to FIN.
  - ARB always costs one cycle between bursts.
- RD:
  - ss_xfer0 = ack_i & (state == RD), combinational.
  - Each ack: rem--, beat++.
  - ss_last0 = ss_xfer0 & (rem == 1).
  - Burst ends (req_o low next cycle, return to ARB) when any of:
    - ack with beat == MAX_BURST-1;
    - ack with rem == 1;
    - ss_stop0 high on any cycle (the in-flight ack in that cycle is still accepted).
- WR:
  - ss_xfer1 = ack_i & (state == WR).
  - Ack with ss_end1 sets wr_done.
  - Burst ends when any of:
    - ack with beat == MAX_BURST-1;
    - ack with ss_end1;
    - ss_stop1 high without an ack in the same cycle.
- FIN:
  - done_o = 1 for one cycle, then IDLE.
- abort_i, in any state except IDLE:
  - drop req_o next cycle, go to CLR, then IDLE (not ARB);
  - no done_o;
  - a beat acked in the abort cycle is still strobed.
- ack_i outside RD/WR is ignored: no strobes, no counter change.
- wb_rst_i mid-burst: immediate return to reset values on the next edge; no done_o, no m_reset0 pulse.
- rem is 24-bit, never decremented below 0. The beat counter is BW bits and never wraps, since the burst ends at MAX_BURST-1.

Optional Feature:
- CH_SCHED_WATCHDOG_EN defined:
  - a counter runs while req_o & ~ack_i and resets on ack or when req_o is low;
  - on reaching WD_CYCLES: set err_o, drop req_o, go to CLR then IDLE, no done_o.
- Undefined: no counter, err_o tied to 0, bus may stall indefinitely.

Test Plan:
- dc0=4, ss_start0=1, ack every cycle, end-marked word returned after 4 writes -> m_reset0 pulses 1 cycle, 4 ss_xfer0 with ss_last0 only on the 4th, one WR burst of 4 ss_xfer1, done_o one cycle, busy_o low after.
- dc0=40, MAX_BURST=16 -> RD bursts of 16/16/8, req_o low for exactly 1 cycle between bursts, ss_last0 only on the 40th beat.
- ss_start0 and ss_start1 both held high, dc0=64 -> grants alternate RD, WR, RD, WR.
- ss_stop0 raised after the 5th ack of a RD burst -> burst ends, rem = dc0-5, next RD burst resumes on ss_start0.
- abort_i asserted mid-WR burst -> req_o low next cycle, one m_reset0 pulse, IDLE, done_o never asserted.
- With CH_SCHED_WATCHDOG_EN, WD_CYCLES=8, ack_i held 0 in RD -> err_o set after 8 cycles, req_o drops, IDLE; the next go_i clears err_o.
